// File: rtl/me_pixel_fetch.sv
// rtl/me_pixel_fetch.sv - byte-serial pixel fetch packing current/reference words for motion estimation
// Optional feature macro: ME_FETCH_CNT_EN adds delivered-word counters cur_words/ref_words.
module me_pixel_fetch #(
  parameter int CUR_BYTES = 8294400,
  parameter int REF_BYTES = 23945760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        need_cur,
  input  logic        need_ref,
  output logic        mem_rd_en,
  output logic        mem_sel,
  output logic [25:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] cur_in,
  output logic [63:0] ref_in,
  output logic        cur_valid,
  output logic        ref_valid,
  output logic        cur_wrap,
  output logic        ref_wrap
`ifdef ME_FETCH_CNT_EN
  ,
  output logic [31:0] cur_words,
  output logic [31:0] ref_words
`endif
);

  typedef enum logic [1:0] {IDLE, CUR, REF} state_t;

  localparam logic [23:0] CUR_LAST = 24'(CUR_BYTES - 1);
  localparam logic [25:0] REF_LAST = 26'(REF_BYTES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        issue, issue_sel;
  logic        cur_done, ref_done;
  logic [23:0] cur_addr;
  logic [25:0] ref_addr;
  logic        cur_wrap_pend, ref_wrap_pend;
  logic        cap_v;
  logic [63:0] sr;

  // State register; cnt tracks position inside the burst including the drain cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Arbitration, read issue and word completion; need_* only matter in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    issue_sel = 1'b0;
    cur_done  = 1'b0;
    ref_done  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (need_cur) begin
          state_nxt = CUR;
          issue     = 1'b1;
        end else if (need_ref) begin
          state_nxt = REF;
          issue     = 1'b1;
          issue_sel = 1'b1;
        end
      end
      CUR: begin
        cnt_nxt = cnt + 4'd1;
        issue   = (cnt < 4'd3);
        if (cnt == 4'd4) begin
          cur_done  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      REF: begin
        cnt_nxt   = cnt + 4'd1;
        issue     = (cnt < 4'd7);
        issue_sel = 1'b1;
        if (cnt == 4'd8) begin
          ref_done  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered read port; address and select hold their last value when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_en <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= 26'd0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_sel  <= issue_sel;
        mem_addr <= issue_sel ? ref_addr : {2'b00, cur_addr};
      end
    end
  end

  // Byte address counters; a wrap inside a burst is remembered until its word is delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr      <= 24'd0;
      ref_addr      <= 26'd0;
      cur_wrap_pend <= 1'b0;
      ref_wrap_pend <= 1'b0;
    end else begin
      if (issue && !issue_sel) begin
        if (cur_addr == CUR_LAST) begin
          cur_addr      <= 24'd0;
          cur_wrap_pend <= 1'b1;
        end else begin
          cur_addr <= cur_addr + 24'd1;
        end
      end else if (cur_done) begin
        cur_wrap_pend <= 1'b0;
      end
      if (issue && issue_sel) begin
        if (ref_addr == REF_LAST) begin
          ref_addr      <= 26'd0;
          ref_wrap_pend <= 1'b1;
        end else begin
          ref_addr <= ref_addr + 26'd1;
        end
      end else if (ref_done) begin
        ref_wrap_pend <= 1'b0;
      end
    end
  end

  // Returning bytes shift in from the top so the first byte ends up lowest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_v <= 1'b0;
      sr    <= 64'd0;
    end else begin
      cap_v <= mem_rd_en;
      if (cap_v) sr <= {mem_rdata, sr[63:8]};
    end
  end

  // Word delivery on the drain edge, merging the final byte straight from memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_in    <= 32'd0;
      ref_in    <= 64'd0;
      cur_valid <= 1'b0;
      ref_valid <= 1'b0;
      cur_wrap  <= 1'b0;
      ref_wrap  <= 1'b0;
    end else begin
      cur_valid <= cur_done;
      ref_valid <= ref_done;
      cur_wrap  <= cur_done & cur_wrap_pend;
      ref_wrap  <= ref_done & ref_wrap_pend;
      if (cur_done) cur_in <= {mem_rdata, sr[63:40]};
      if (ref_done) ref_in <= {mem_rdata, sr[63:8]};
    end
  end

`ifdef ME_FETCH_CNT_EN
  // Delivered-word counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_words <= 32'd0;
      ref_words <= 32'd0;
    end else begin
      if (cur_valid) cur_words <= cur_words + 32'd1;
      if (ref_valid) ref_words <= ref_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_me_pixel_fetch.sv
// tb/tb_me_pixel_fetch.sv - scoreboard bench for me_pixel_fetch with small wrapping frame sizes
module tb_me_pixel_fetch;

  localparam int CB = 6;
  localparam int RB = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        need_cur = 1'b0;
  logic        need_ref = 1'b0;
  logic        mem_rd_en, mem_sel;
  logic [25:0] mem_addr;
  logic [7:0]  mem_rdata = 8'd0;
  logic [31:0] cur_in;
  logic [63:0] ref_in;
  logic        cur_valid, ref_valid, cur_wrap, ref_wrap;
`ifdef ME_FETCH_CNT_EN
  logic [31:0] cur_words, ref_words;
`endif

  me_pixel_fetch #(.CUR_BYTES(CB), .REF_BYTES(RB)) dut (
    .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref),
    .mem_rd_en(mem_rd_en), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cur_in(cur_in), .ref_in(ref_in), .cur_valid(cur_valid), .ref_valid(ref_valid),
    .cur_wrap(cur_wrap), .ref_wrap(ref_wrap)
`ifdef ME_FETCH_CNT_EN
    , .cur_words(cur_words), .ref_words(ref_words)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cur_ptr = 0;
  int ref_ptr = 0;
  int n_cur_done = 0;
  int n_ref_done = 0;
  logic [31:0] cur_exp_q[$];
  logic        cur_wexp_q[$];
  logic [63:0] ref_exp_q[$];
  logic        ref_wexp_q[$];
  logic [31:0] prev_cur = 32'd0;
  logic [63:0] prev_ref = 64'd0;

  function automatic logic [7:0] cur_byte(input int a);
    return 8'(a & 255);
  endfunction

  function automatic logic [7:0] ref_byte(input int a);
    return 8'((a + 16) & 255);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, expected DUT response", name);
  endtask

  // Reference model: a word is the next N bytes of a circular frame, wrap when the frame end is crossed.
  task automatic push_cur();
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = cur_byte((cur_ptr + k) % CB);
    cur_exp_q.push_back(w);
    cur_wexp_q.push_back(cur_ptr + 4 >= CB);
    cur_ptr = (cur_ptr + 4) % CB;
  endtask

  task automatic push_ref();
    logic [63:0] w;
    w = 64'd0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_byte((ref_ptr + k) % RB);
    ref_exp_q.push_back(w);
    ref_wexp_q.push_back(ref_ptr + 8 >= RB);
    ref_ptr = (ref_ptr + 8) % RB;
  endtask

  // Pixel memory: byte returned one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= mem_sel ? ref_byte(int'(mem_addr)) : cur_byte(int'(mem_addr));
    else
      mem_rdata <= 8'($urandom);
  end

  // Monitor: pops expected words on each valid pulse and watches that outputs hold otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      prev_cur = 32'd0;
      prev_ref = 64'd0;
    end else begin
      if (cur_valid) begin
        if (cur_exp_q.size() == 0) timeout("cur_unexpected_valid");
        else begin
          check("cur_word", 64'(cur_in), 64'(cur_exp_q.pop_front()));
          check("cur_wrap", 64'(cur_wrap), 64'(cur_wexp_q.pop_front()));
          n_cur_done++;
        end
      end else begin
        if (cur_wrap) check("cur_wrap_alone", 64'(cur_wrap), 64'd0);
        if (cur_in !== prev_cur) check("cur_hold", 64'(cur_in), 64'(prev_cur));
      end
      if (ref_valid) begin
        if (ref_exp_q.size() == 0) timeout("ref_unexpected_valid");
        else begin
          check("ref_word", ref_in, ref_exp_q.pop_front());
          check("ref_wrap", 64'(ref_wrap), 64'(ref_wexp_q.pop_front()));
          n_ref_done++;
        end
      end else begin
        if (ref_wrap) check("ref_wrap_alone", 64'(ref_wrap), 64'd0);
        if (ref_in !== prev_ref) check("ref_hold", ref_in, prev_ref);
      end
      if (mem_rd_en)
        check("addr_range", 64'(mem_sel ? (int'(mem_addr) < RB) : (int'(mem_addr) < CB)), 64'd1);
      prev_cur = cur_in;
      prev_ref = ref_in;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (cur_exp_q.size() == 0 && ref_exp_q.size() == 0) return;
    end
    timeout("drain");
  endtask

  // Issue one request pattern; when both are raised need_ref is kept up until the cur burst ends.
  task automatic issue(input bit c, input bit r);
    need_cur = c;
    need_ref = r;
    if (c) push_cur();
    if (r) push_ref();
    @(posedge clk); #1;
    need_cur = 1'b0;
    if (!c) need_ref = 1'b0;
    if (c && r) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cur_valid) break;
        if (i == 19) timeout("both_cur_valid");
      end
      @(negedge clk);
      need_ref = 1'b0;
    end
  endtask

  // Count negedges after the sampling edge until the valid pulse is seen.
  task automatic wait_valid(input bit is_ref, output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (is_ref ? ref_valid : cur_valid) begin
        lat = i;
        return;
      end
    end
    timeout(is_ref ? "ref_valid_wait" : "cur_valid_wait");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_sel"}, 64'(mem_sel), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_cur_in"}, 64'(cur_in), 64'd0);
    check({tag, "_ref_in"}, ref_in, 64'd0);
    check({tag, "_pulses"}, 64'({cur_valid, ref_valid, cur_wrap, ref_wrap}), 64'd0);
  endtask

  initial begin
    int lat, t1, t2;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single cur pulse from address 0: valid lands in the cycle opened 5 edges after sampling.
    push_cur();
    need_cur = 1'b1;
    @(posedge clk); #1 need_cur = 1'b0;
    wait_valid(1'b0, lat);
    check("cur_latency", 64'(lat), 64'd6);
    check("cur_first_word", 64'(cur_in), 64'h03020100);
    wait_drain();

    // Held need_ref: two back-to-back words separated by one idle cycle.
    push_ref();
    push_ref();
    need_ref = 1'b1;
    @(posedge clk); #1;
    wait_valid(1'b1, t1);
    check("ref_latency", 64'(t1), 64'd10);
    check("ref_first_word", ref_in, 64'h1716151413121110);
    @(negedge clk);
    need_ref = 1'b0;
    wait_valid(1'b1, t2);
    check("ref_gap", 64'(t2), 64'd9);
    check("ref_second_word", ref_in, 64'h1F1E1D1C1B1A1918);
    wait_drain();

    // Second cur word crosses the 6-byte frame end: addresses 4,5,0,1.
    @(negedge clk);
    issue(1'b1, 1'b0);
    wait_drain();
    check("cur_wrap_word", 64'(cur_in), 64'h01000504);

    // Both requests together: cur first, then ref.
    @(negedge clk);
    issue(1'b1, 1'b1);
    wait_drain();

    // Reset in the middle of a ref burst (count 4).
    @(negedge clk);
    need_ref = 1'b1;
    @(posedge clk); #1 need_ref = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    cur_ptr = 0;
    ref_ptr = 0;
    n_cur_done = 0;
    n_ref_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    issue(1'b0, 1'b1);
    wait_drain();
    check("ref_after_reset", ref_in, 64'h1716151413121110);

    // Randomized traffic mix.
    for (int n = 0; n < 30; n++) begin
      int kind;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = $urandom_range(0, 2);
      issue(kind != 1, kind != 0);
      wait_drain();
    end
    check("cur_queue_empty", 64'(cur_exp_q.size()), 64'd0);
    check("ref_queue_empty", 64'(ref_exp_q.size()), 64'd0);

`ifdef ME_FETCH_CNT_EN
    @(negedge clk);
    check("cur_words", 64'(cur_words), 64'(n_cur_done));
    check("ref_words", 64'(ref_words), 64'(n_ref_done));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
